mult_add_issuer: RTL and testbench

- Initiator-side companion to the mult_add floating-point datapath.
- Accepts operand triplets {A,B,C} on a valid/ready stream and drives them into mult_add.
- Tracks each operation through mult_add's fixed, un-handshaked pipeline with a tag shift register, and aligns mult_result with add_result.
- Returns results on a backpressured valid/ready stream through a credit-protected output FIFO, so no in-flight result is ever dropped.

---
 rtl/mult_add_pkg.sv | 13 +
 rtl/result_fifo.sv | 42 ++++
 rtl/mult_add_issuer.sv | 124 ++++++++++++
 tb/tb_mult_add_issuer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_add_pkg.sv
// rtl/mult_add_pkg.sv - shared defaults and FSM state type for the mult_add issuer
package mult_add_pkg;
  localparam int PRECISION_DEF = 32;
  localparam int MULT_LAT_DEF  = 11;
  localparam int ADD_LAT_DEF   = 26;
  localparam int DEPTH_DEF     = 8;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } issuer_state_t;
endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous show-ahead FIFO with occupancy count
module result_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/mult_add_issuer.sv
// rtl/mult_add_issuer.sv - feeds operand triplets into mult_add and returns aligned result pairs
module mult_add_issuer
  import mult_add_pkg::*;
#(
  parameter int PRECISION = PRECISION_DEF,
  parameter int MULT_LAT  = MULT_LAT_DEF,
  parameter int ADD_LAT   = ADD_LAT_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  localparam int IW = $clog2(ADD_LAT + 1),
  localparam int FW = $clog2(DEPTH) + 1,
  localparam int DL = ADD_LAT - MULT_LAT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PRECISION-1:0] in_a,
  input  logic [PRECISION-1:0] in_b,
  input  logic [PRECISION-1:0] in_c,
  output logic [PRECISION-1:0] op_a,
  output logic [PRECISION-1:0] op_b,
  output logic [PRECISION-1:0] op_c,
  input  logic [PRECISION-1:0] mult_result,
  input  logic [PRECISION-1:0] add_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PRECISION-1:0] out_mult,
  output logic [PRECISION-1:0] out_add,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic [IW-1:0]        inflight
);
  localparam logic [31:0] DEPTH_U = DEPTH;

  issuer_state_t        state;
  issuer_state_t        state_nx;
  logic                 flush_done_nx;
  logic                 ready_en;
  logic [ADD_LAT-1:0]   tag;
  logic [PRECISION-1:0] mult_dly [DL];
  logic [FW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 issue;
  logic                 capture;
  logic                 pop;

  // Credits count both queued results and ops still inside mult_add, so a capture always finds room.
  assign in_ready  = ready_en && (state == RUN) && ((32'(fifo_count) + 32'(inflight)) < DEPTH_U);
  assign issue     = in_valid && in_ready;
  assign capture   = tag[ADD_LAT-1];
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    flush_done_nx = 1'b0;
    case (state)
      RUN:   if (flush_req) state_nx = DRAIN;
      DRAIN: begin
        if ((inflight == '0) && fifo_empty) begin
          state_nx      = DONE;
          flush_done_nx = 1'b1;
        end
      end
      DONE:  if (!flush_req) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en   <= 1'b0;
      flush_done <= 1'b0;
      tag        <= '0;
      inflight   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_c       <= '0;
    end else begin
      ready_en   <= 1'b1;
      flush_done <= flush_done_nx;
      tag        <= {tag[ADD_LAT-2:0], issue};
      if (issue) begin
        op_a <= in_a;
        op_b <= in_b;
        op_c <= in_c;
      end
      case ({issue, capture})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // mult_result is valid MULT_LAT edges after issue; hold it until add_result catches up.
  always_ff @(posedge clk) begin
    mult_dly[0] <= mult_result;
    for (int i = 1; i < DL; i++) mult_dly[i] <= mult_dly[i-1];
  end

  result_fifo #(
    .WIDTH(2 * PRECISION),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (capture),
    .push_data({mult_dly[DL-1], add_result}),
    .pop      (pop),
    .pop_data ({out_mult, out_add}),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n) !(capture && fifo_full));
endmodule

// File: tb/tb_mult_add_issuer.sv
// tb/tb_mult_add_issuer.sv - self-checking bench for mult_add_issuer
module tb_mult_add_issuer;
  import mult_add_pkg::*;

  localparam int P  = PRECISION_DEF;
  localparam int ML = MULT_LAT_DEF;
  localparam int AL = ADD_LAT_DEF;
  localparam int IW = $clog2(AL + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid [2];
  logic          out_ready [2];
  logic          flush_req [2];
  logic [P-1:0]  in_a [2];
  logic [P-1:0]  in_b [2];
  logic [P-1:0]  in_c [2];
  logic          in_ready [2];
  logic          out_valid [2];
  logic          flush_done [2];
  logic [P-1:0]  out_mult [2];
  logic [P-1:0]  out_add [2];
  logic [IW-1:0] inflight [2];

  int checks = 0;
  int errors = 0;
  bit chk_ready = 1'b1;
  int tcyc = 0;
  int done_cnt [2];
  int pop_cnt [2];
  int first_pop [2];
  int last_pop [2];

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endfunction

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) return 0.0;
    d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] fmsub(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return r2f(f2r(c) - f2r(a) * f2r(b));
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int DEP = (g == 0) ? 8 : 32;
    logic [P-1:0] op_a, op_b, op_c, mult_result, add_result;
    logic [P-1:0] mpipe [ML-1];
    logic [P-1:0] apipe [AL-1];
    int           iss_q [$];
    logic [63:0]  pend_q [$];
    logic [63:0]  fifo_q [$];
    int           cyc;
    bit           live;

    mult_add_issuer #(.PRECISION(P), .MULT_LAT(ML), .ADD_LAT(AL), .DEPTH(DEP)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_a(in_a[g]), .in_b(in_b[g]), .in_c(in_c[g]),
      .op_a(op_a), .op_b(op_b), .op_c(op_c),
      .mult_result(mult_result), .add_result(add_result),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_mult(out_mult[g]), .out_add(out_add[g]),
      .flush_req(flush_req[g]), .flush_done(flush_done[g]),
      .inflight(inflight[g])
    );

    // Stand-in for the un-handshaked mult_add pipeline: reads op_* every edge.
    always @(posedge clk) begin
      mpipe[0] <= fmul(op_a, op_b);
      apipe[0] <= fmsub(op_a, op_b, op_c);
      for (int i = 1; i < ML - 1; i++) mpipe[i] <= mpipe[i-1];
      for (int i = 1; i < AL - 1; i++) apipe[i] <= apipe[i-1];
    end
    assign mult_result = mpipe[ML-2];
    assign add_result  = apipe[AL-2];

    // Transaction-level reference: each op lands in the output queue AL edges after its handshake.
    always @(negedge clk) begin
      if (!reset_n) begin
        iss_q.delete();
        pend_q.delete();
        fifo_q.delete();
        cyc  = 0;
        live = 1'b0;
      end else begin
        chk($sformatf("u%0d out_valid", g), 64'(out_valid[g]), 64'(fifo_q.size() > 0));
        if (fifo_q.size() > 0) chk($sformatf("u%0d result", g), {out_mult[g], out_add[g]}, fifo_q[0]);
        chk($sformatf("u%0d inflight", g), 64'(inflight[g]), 64'(iss_q.size()));
        if (chk_ready)
          chk($sformatf("u%0d in_ready", g), 64'(in_ready[g]),
              64'(live && (fifo_q.size() + iss_q.size() < DEP)));
        cyc++;
        if (fifo_q.size() > 0 && out_ready[g]) void'(fifo_q.pop_front());
        if (iss_q.size() > 0 && iss_q[0] + AL == cyc) begin
          void'(iss_q.pop_front());
          fifo_q.push_back(pend_q.pop_front());
        end
        if (in_valid[g] && in_ready[g]) begin
          iss_q.push_back(cyc);
          pend_q.push_back({fmul(in_a[g], in_b[g]), fmsub(in_a[g], in_b[g], in_c[g])});
        end
        live = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    tcyc++;
    for (int g = 0; g < 2; g++) begin
      if (flush_done[g]) done_cnt[g]++;
      if (out_valid[g] && out_ready[g]) begin
        if (first_pop[g] < 0) first_pop[g] = tcyc;
        last_pop[g] = tcyc;
        pop_cnt[g]++;
      end
    end
  end

  typedef struct {
    logic [31:0] a, b, c, exp_mult, exp_add;
  } vec_t;
  vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd(input int g);
    in_a[g] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    in_b[g] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    in_c[g] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
  endtask

  task automatic stream(input int g, input int n, input int max_cyc, output int acc);
    int t;
    t = 0;
    acc = 0;
    rnd(g);
    in_valid[g] = 1'b1;
    while (acc < n && t < max_cyc) begin
      if (in_ready[g]) begin
        step();
        acc++;
        rnd(g);
      end else begin
        step();
      end
      t++;
    end
    in_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input string nm);
    int w;
    w = 0;
    while ((out_valid[g] || inflight[g] != '0) && w < 200) begin
      step();
      w++;
    end
    chk({nm, " idle"}, 64'(w < 200), 64'd1);
  endtask

  task automatic single_op(input int g, input vec_t v, input string nm);
    int n;
    int w;
    in_a[g] = v.a;
    in_b[g] = v.b;
    in_c[g] = v.c;
    in_valid[g] = 1'b1;
    w = 0;
    while (!in_ready[g] && w < 50) begin
      step();
      w++;
    end
    chk({nm, " accept"}, 64'(w < 50), 64'd1);
    step();
    in_valid[g] = 1'b0;
    n = 1;
    while (!out_valid[g] && n < 60) begin
      step();
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'd27);
    chk({nm, " mult"}, 64'(out_mult[g]), 64'(v.exp_mult));
    chk({nm, " add"}, 64'(out_add[g]), 64'(v.exp_add));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc2;
    int viol;
    int w;
    int pops0;
    vecs[0] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h40C00000, 32'hC0A00000};
    vecs[1] = '{32'h3FC00000, 32'h40000000, 32'h40800000, 32'h40400000, 32'h3F800000};
    vecs[2] = '{32'hBF800000, 32'h40800000, 32'h00000000, 32'hC0800000, 32'h40800000};
    vecs[3] = '{32'h3F000000, 32'h3F000000, 32'h3E800000, 32'h3E800000, 32'h00000000};
    vecs[4] = '{32'h40400000, 32'hC0000000, 32'h3F800000, 32'hC0C00000, 32'h40E00000};
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0;
      out_ready[g] = 1'b1;
      flush_req[g] = 1'b0;
      in_a[g] = '0;
      in_b[g] = '0;
      in_c[g] = '0;
      done_cnt[g] = 0;
      pop_cnt[g] = 0;
      first_pop[g] = -1;
      last_pop[g] = -1;
    end

    repeat (3) step();
    for (int g = 0; g < 2; g++) begin
      chk("reset in_ready", 64'(in_ready[g]), 64'd0);
      chk("reset out_valid", 64'(out_valid[g]), 64'd0);
      chk("reset inflight", 64'(inflight[g]), 64'd0);
      chk("reset flush_done", 64'(flush_done[g]), 64'd0);
    end
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) single_op(0, vecs[i], $sformatf("vec%0d", i));
    wait_idle(0, "vectors");

    pop_cnt[1] = 0;
    first_pop[1] = -1;
    stream(1, 40, 80, acc);
    chk("stream accepted", 64'(acc), 64'd40);
    wait_idle(1, "stream");
    chk("stream results", 64'(pop_cnt[1]), 64'd40);
    chk("stream gapless", 64'(last_pop[1] - first_pop[1]), 64'd39);

    out_ready[0] = 1'b0;
    stream(0, 100, 60, acc);
    chk("bp accepted", 64'(acc), 64'd8);
    chk("bp in_ready held", 64'(in_ready[0]), 64'd0);
    out_ready[0] = 1'b1;
    stream(0, 100, 40, acc2);
    chk("bp issue resumes", 64'(acc2 > 0), 64'd1);
    wait_idle(0, "bp");

    chk_ready = 1'b0;
    pops0 = pop_cnt[0];
    stream(0, 5, 20, acc);
    chk("flush issued", 64'(acc), 64'd5);
    step();
    flush_req[0] = 1'b1;
    step();
    chk("flush in_ready", 64'(in_ready[0]), 64'd0);
    in_valid[0] = 1'b1;
    w = 0;
    while (!flush_done[0] && w < 80) begin
      step();
      w++;
    end
    chk("flush_done seen", 64'(w < 80), 64'd1);
    repeat (4) step();
    chk("flush hold in_ready", 64'(in_ready[0]), 64'd0);
    in_valid[0] = 1'b0;
    flush_req[0] = 1'b0;
    step();
    chk("flush back to run", 64'(in_ready[0]), 64'd1);
    chk("flush pulses", 64'(done_cnt[0]), 64'd1);
    chk("flush results", 64'(pop_cnt[0] - pops0), 64'd5);
    chk_ready = 1'b1;

    stream(1, 10, 20, acc);
    chk("rst issued", 64'(acc), 64'd10);
    repeat (5) step();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid[1] || inflight[1] != '0) viol++;
    end
    chk("rst quiet", 64'(viol), 64'd0);
    single_op(1, vecs[0], "post-reset");

    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
